// File: rtl/Isa.sv
// Isa: shared register width, ALU opcodes and the packet layout sent over the ALU SPI link.
package Isa;
  localparam int REGISTER_SIZE = 8;
  typedef enum logic [2:0] {ADD, SUB, AND, OR, XOR, SLL, SRL, SLT} AluOperation;
  typedef struct packed {
    logic [REGISTER_SIZE-1:0] b;
    logic [REGISTER_SIZE-1:0] a;
    AluOperation              op;
  } AluPacket;
endpackage

// File: rtl/Spi.sv
// Spi: processor-to-ALU serial link; sclk mirrors the system clock.
interface Spi;
  logic sclk;
  logic nss;
  logic mosi;
  logic miso;
  modport SlaveSpi (input sclk, nss, mosi, output miso);
  modport MasterSpi (output sclk, nss, mosi, input miso);
endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU, (op, a, b) -> result.
module alu_core import Isa::*; #(
  parameter int DATA_WIDTH = REGISTER_SIZE,
  parameter int OP_WIDTH   = $bits(AluOperation)
) (
  input  logic [OP_WIDTH-1:0]   i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_result
);
  localparam int SW = $clog2(DATA_WIDTH);
  AluOperation   w_op;
  logic [SW-1:0] w_sh;
  logic          w_lt;
  assign w_op = AluOperation'(i_op);
  assign w_sh = i_b[SW-1:0];
  assign w_lt = $signed(i_a) < $signed(i_b);
  always_comb
    o_result = w_op == ADD ? i_a + i_b :
               w_op == SUB ? i_a - i_b :
               w_op == AND ? i_a & i_b :
               w_op == OR  ? i_a | i_b :
               w_op == XOR ? i_a ^ i_b :
               w_op == SLL ? i_a << w_sh :
               w_op == SRL ? i_a >> w_sh :
               {{(DATA_WIDTH-1){1'b0}}, w_lt};
endmodule

// File: rtl/spi_alu.sv
// spi_alu: SPI slave that receives an ALU packet LSB-first, computes, and returns a start bit plus the result.
module spi_alu import Isa::*; #(
  parameter int DATA_WIDTH = REGISTER_SIZE,
  parameter int OP_WIDTH   = $bits(AluOperation)
) (
  input  logic i_clock,
  input  logic i_reset,
  Spi.SlaveSpi spi,
  output logic o_busy
);
  localparam int PACKET_BITS = 2 * DATA_WIDTH + OP_WIDTH;
  localparam int RXW = $clog2(PACKET_BITS);
  localparam int TXW = $clog2(DATA_WIDTH);
  localparam logic [RXW-1:0] RX_LAST = RXW'(PACKET_BITS - 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(DATA_WIDTH - 1);
  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    RECEIVING = 5'b00010,
    COMPUTE   = 5'b00100,
    START     = 5'b01000,
    TRANSMIT  = 5'b10000
  } state_t;
  state_t                 r_state, w_next;
  logic [RXW-1:0]         r_rx_cnt;
  logic [TXW-1:0]         r_tx_cnt;
  logic [PACKET_BITS-1:0] r_packet;
  logic [DATA_WIDTH-1:0]  r_result, w_result;
  logic                   w_unused_sclk;
  assign w_unused_sclk = spi.sclk;
  alu_core #(.DATA_WIDTH(DATA_WIDTH), .OP_WIDTH(OP_WIDTH)) u_core (
    .i_op     (r_packet[OP_WIDTH-1:0]),
    .i_a      (r_packet[OP_WIDTH+DATA_WIDTH-1:OP_WIDTH]),
    .i_b      (r_packet[PACKET_BITS-1:OP_WIDTH+DATA_WIDTH]),
    .o_result (w_result)
  );
  // nss high outside IDLE aborts; illegal one-hot codes fall back to IDLE
  always_comb
    w_next = r_state != IDLE && spi.nss ? IDLE :
             r_state == IDLE ? (!spi.nss && spi.mosi ? RECEIVING : IDLE) :
             r_state == RECEIVING ? (r_rx_cnt == RX_LAST ? COMPUTE : RECEIVING) :
             r_state == COMPUTE ? START :
             r_state == START ? TRANSMIT :
             r_state == TRANSMIT && r_tx_cnt != TX_LAST ? TRANSMIT : IDLE;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_rx_cnt <= '0;
      r_tx_cnt <= '0;
      r_packet <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_next;
      r_rx_cnt <= r_state == RECEIVING && w_next == RECEIVING ? r_rx_cnt + 1'b1 : '0;
      r_tx_cnt <= r_state == TRANSMIT && w_next == TRANSMIT ? r_tx_cnt + 1'b1 : '0;
      if (r_state == RECEIVING && !spi.nss) r_packet[r_rx_cnt] <= spi.mosi;
      if (r_state == COMPUTE && !spi.nss) r_result <= w_result;
    end
  end
  assign spi.miso = r_state == START || (r_state == TRANSMIT && r_result[r_tx_cnt]);
  assign o_busy   = r_state != IDLE;
endmodule

// File: tb/tb_spi_alu.sv
// tb_spi_alu: drives packets as the processor would; a monitor decodes returned frames against a queue of model results.
module tb_spi_alu;
  logic clk = 0;
  logic rst = 1;
  logic busy;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  Spi spi();
  assign spi.sclk = clk;
  always #5 clk = ~clk;

  spi_alu dut (.i_clock(clk), .i_reset(rst), .spi(spi), .o_busy(busy));

  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia = a, ib = b, sh = b % 8, r = 0;
    int sa = ia > 127 ? ia - 256 : ia;
    int sb = ib > 127 ? ib - 256 : ib;
    case (op)
      0: r = (ia + ib) % 256;
      1: r = (ia - ib + 256) % 256;
      2: r = ia & ib;
      3: r = ia | ib;
      4: r = ia ^ ib;
      5: r = (ia * (2 ** sh)) % 256;
      6: r = ia / (2 ** sh);
      default: r = sa < sb ? 1 : 0;
    endcase
    return r[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // abort_bit/reset_bit < 0 disable the respective disruption
  task automatic xact(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input int abort_bit = -1, input int reset_bit = -1);
    logic [18:0] pkt;
    pkt = {b, a, op};
    spi.nss = 0;
    spi.mosi = 1;
    tick();
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 19; i++) begin
      if (i == abort_bit) begin
        spi.nss = 1;
        spi.mosi = $urandom_range(1);
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_miso", spi.miso, 0);
        tick();
        chk("abort_idle_miso", spi.miso, 0);
        spi.mosi = 0;
        spi.nss = 0;
        return;
      end
      spi.mosi = pkt[i];
      tick();
      if (i < 18) chk("rx_miso_low", spi.miso, 0);
    end
    if (reset_bit < 0) exp_q.push_back(model(op, a, b));
    chk("compute_miso", spi.miso, 0);
    chk("compute_busy", busy, 1);
    spi.mosi = $urandom_range(1);
    tick();
    chk("start_miso", spi.miso, 1);
    for (int k = 0; k < 8; k++) begin
      spi.mosi = $urandom_range(1);
      tick();
      chk("tx_busy", busy, 1);
      if (k == reset_bit) begin
        rst = 1;
        tick();
        chk("reset_miso", spi.miso, 0);
        chk("reset_busy", busy, 0);
        rst = 0;
        spi.mosi = 0;
        return;
      end
    end
    spi.mosi = 0;
    tick();
    chk("end_busy", busy, 0);
    chk("end_miso", spi.miso, 0);
  endtask

  initial begin : monitor
    logic [7:0] got;
    int n = 0;
    bit collecting = 0;
    forever begin
      tick();
      if (collecting) begin
        if (!busy) collecting = 0;
        else begin
          got[n] = spi.miso;
          n++;
          if (n == 8) begin
            collecting = 0;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame got %0h expected none", got);
            end else chk("result", got, exp_q.pop_front());
          end
        end
      end else if (busy && spi.miso) begin
        collecting = 1;
        n = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    spi.nss = 1;
    spi.mosi = 0;
    rst = 1;
    tick();
    tick();
    chk("reset_busy0", busy, 0);
    chk("reset_miso0", spi.miso, 0);
    rst = 0;
    spi.mosi = 1;
    tick();
    chk("nss_high_no_start", busy, 0);
    spi.nss = 0;
    spi.mosi = 0;
    tick();
    chk("mosi_low_no_start", busy, 0);
    xact(0, 8'h7F, 8'h01);
    xact(1, 8'h00, 8'h01);
    xact(7, 8'hFF, 8'h01);
    xact(7, 8'h01, 8'hFF);
    xact(5, 8'h81, 8'h0B);
    xact(6, 8'h80, 8'h07);
    xact(0, 8'h12, 8'h34, 10);
    xact(2, 8'hF0, 8'h3C);
    xact(3, 8'h55, 8'h0F, -1, 3);
    xact(4, 8'hAA, 8'hFF);
    for (int t = 0; t < 40; t++) begin
      xact(3'($urandom_range(7)), 8'($urandom), 8'($urandom),
           $urandom_range(9) == 0 ? int'($urandom_range(18)) : -1,
           $urandom_range(9) == 0 ? int'($urandom_range(7)) : -1);
      repeat ($urandom_range(2)) tick();
    end
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_alu.md
# spi_alu

Serial ALU slave on the processor's SPI link: receives one operation packet (opcode plus two operands) from the processor, computes the result, and returns it serially on the same link. It sits directly downstream of the processor's ALU_SEND/ALU_SENDING states and upstream of its ALU_RECEIVE/ALU_RECEIVING/ALU_STORE states. One packet in, one result out per transaction; no pipelining.

## Interface

- DATA_WIDTH, default `Isa::REGISTER_SIZE` (8): operand and result width.
- OP_WIDTH, default `$bits(Isa::AluOperation)` (3): opcode width.
- i_clock  in  1  system clock; spi.sclk is the same net and is not used as a clock.
- i_reset  in  1  synchronous, active-high reset.
- spi  `Spi.SlaveSpi` modport  —  nss (in, active-low select), mosi (in), miso (out), sclk (in, unused).
- o_busy  out  1  high whenever the FSM is not in IDLE.

## Operation

- Packet layout (`Isa::AluPacket`, PACKET_BITS = 2·DATA_WIDTH + OP_WIDTH = 19), bit 0 sent first:
  - [OP_WIDTH-1:0] op
  - [OP_WIDTH+DATA_WIDTH-1:OP_WIDTH] a (value of rs_1)
  - [PACKET_BITS-1:OP_WIDTH+DATA_WIDTH] b (value of rs_2)
- States, one-hot: IDLE, RECEIVING, COMPUTE, START, TRANSMIT.
  - IDLE: miso=0. If nss=0 and mosi=1 → RECEIVING, rx counter=0.
  - RECEIVING: shift register bit[rx_cnt] ← mosi each edge. At rx_cnt == PACKET_BITS-1 → COMPUTE.
  - COMPUTE: miso=0. Register result from the captured packet. → START.
  - START: miso=1 for exactly one cycle. → TRANSMIT, tx counter=0.
  - TRANSMIT: miso=result[tx_cnt]. At tx_cnt == DATA_WIDTH-1 → IDLE.
- Opcodes (`Isa::AluOperation`): ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SLT=7.
  - ADD/SUB wrap modulo 2^DATA_WIDTH.
  - SLL/SRL shift a by b[$clog2(DATA_WIDTH)-1:0]; upper bits of b are ignored.
  - SLT: signed a < b → 1, else 0, zero-extended.
- Abort: nss=1 in any non-IDLE state → IDLE at the next edge, miso=0, counters cleared; the partial packet is discarded.
- The start bit is recognised only in IDLE. mosi activity during COMPUTE, START or TRANSMIT is ignored.

## Timing

- Reset values: miso=0, o_busy=0, state=IDLE, counters=0, packet and result registers=0. Reset overrides abort and all other events.
- Cycle S: nss=0, mosi=1 sampled in IDLE.
- Cycles S+1 … S+19: packet bits 0…18 sampled.
- Cycle S+20: COMPUTE.
- Cycle S+21: START (miso=1).
- Cycles S+22 … S+29: result bits 0…7 driven.
- Cycle S+30: back in IDLE.
- Transaction length: 2 + PACKET_BITS + DATA_WIDTH + 1 = 30 cycles from start bit to IDLE. This matches the processor, which samples miso one cycle after it observes miso=1.
- miso is registered: it comes from state and counter flops, with no combinational path from mosi or nss.
- Back-to-back: a new start bit is accepted on the cycle of the return to IDLE (S+30).

## Structure

- Package `Isa` holds REGISTER_SIZE, the `AluOperation` enum, and the `AluPacket` packed struct (b, a, op — op at LSBs). This block adds no new package content except the opcode encodings above if they are not already present.
- Sub-module `alu_core`: purely combinational (op, a, b) → result, parameterised by DATA_WIDTH. It is instantiated once and fed from the captured packet, with its output registered in COMPUTE.
- The FSM state typedef stays local to spi_alu.

## Test plan

- ADD: a=8'h7F, b=8'h01 → result bits LSB-first of 8'h80; miso=1 exactly at S+21; o_busy high S+1…S+29.
- SUB wrap: a=8'h00, b=8'h01 → 8'hFF. SLT signed: a=8'hFF, b=8'h01 → 8'h01. SLT: a=8'h01, b=8'hFF → 8'h00.
- SLL: a=8'h81, b=8'h0B → shift by 3 → 8'h08. SRL: a=8'h80, b=8'h07 → 8'h01.
- Abort: raise nss at bit 10 of the packet → IDLE next edge, miso stays 0. A subsequent full AND transaction with a=8'hF0, b=8'h3C → 8'h30.
- Reset mid-TRANSMIT (i_reset=1 at result bit 3) → next edge miso=0, o_busy=0. A fresh XOR with a=8'hAA, b=8'hFF → 8'h55.
- End-to-end: processor plus spi_alu, registers r1=5, r2=3, instruction ADD rd=r4 → r4=8 after ALU_STORE. A second back-to-back OR instruction completes correctly.
